// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - state encoding and vector constants shared by fetch_unit
package fetch_pkg;

    typedef enum logic [2:0] {
        S_VEC,
        S_RUN,
        S_IMM,
        S_INT,
        S_HALT
    } fetch_state_t;

    localparam logic [7:0] RESET_VEC_DEFAULT    = 8'h00;
    localparam logic [7:0] INT_VEC_DEFAULT      = 8'h01;
    localparam logic [3:0] TWO_BYTE_OPC_DEFAULT = 4'hC;

    function automatic logic is_two_byte(input logic [3:0] opc, input logic [3:0] two_byte_opc);
        return opc == two_byte_opc;
    endfunction

endpackage

// File: rtl/int_edge_latch.sv
// rtl/int_edge_latch.sv - interrupt rising-edge detector and pending flag
// Built only with FETCH_INT_EN; otherwise pending is tied low.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic int_line,
    input  logic clr,
    output logic pending
);

`ifdef FETCH_INT_EN
    logic int_prev;

    // A new edge wins over clr so an edge landing on the acceptance cycle re-arms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            int_prev <= int_line;
            if (int_line && !int_prev)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, int_line, clr};
    assign pending       = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end filling the IF/ID register
// Interrupt support is compiled in with FETCH_INT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W         = 8,
    parameter int              DATA_W         = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = RESET_VEC_DEFAULT,
    parameter logic [ADDR_W-1:0] INT_VEC_ADDR   = INT_VEC_DEFAULT,
    parameter logic [3:0]      TWO_BYTE_OPC   = TWO_BYTE_OPC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              int_line,
    output logic              int_ack,
    output logic [ADDR_W-1:0] int_ret_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [DATA_W-1:0] ifid_imm,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              HLT
);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc_d, ifid_pc_d, ret_d;
    logic [DATA_W-1:0] instr_d, imm_d, held, held_d;
    logic              valid_d, ack_d, hlt_d;
    logic              int_pending, int_clr;

    int_edge_latch u_int_edge_latch (
        .clk      (clk),
        .rst      (rst),
        .int_line (int_line),
        .clr      (int_clr),
        .pending  (int_pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_VEC;
            pc         <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_imm   <= '0;
            ifid_pc    <= '0;
            held       <= '0;
            int_ret_pc <= '0;
            int_ack    <= 1'b0;
            HLT        <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            ifid_valid <= valid_d;
            ifid_instr <= instr_d;
            ifid_imm   <= imm_d;
            ifid_pc    <= ifid_pc_d;
            held       <= held_d;
            int_ret_pc <= ret_d;
            int_ack    <= ack_d;
            HLT        <= hlt_d;
        end
    end

    always_comb begin
        state_d   = state;
        mem_addr  = pc;
        pc_d      = pc;
        valid_d   = ifid_valid;
        instr_d   = ifid_instr;
        imm_d     = ifid_imm;
        ifid_pc_d = ifid_pc;
        held_d    = held;
        ret_d     = int_ret_pc;
        ack_d     = 1'b0;
        hlt_d     = HLT;
        int_clr   = 1'b0;

        case (state)
            S_VEC: begin
                mem_addr = RESET_VEC_ADDR;
                pc_d     = ADDR_W'(mem_rdata);
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (halt_req) begin
                    valid_d = 1'b0;
                    hlt_d   = 1'b1;
                    state_d = S_HALT;
                end else if (stall) begin
                    state_d = S_RUN;
                end else if (int_pending) begin
                    ret_d   = pc;
                    ack_d   = 1'b1;
                    int_clr = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_INT;
                end else if (is_two_byte(mem_rdata[DATA_W-1 -: 4], TWO_BYTE_OPC)) begin
                    held_d  = mem_rdata;
                    valid_d = 1'b0;
                    pc_d    = pc + ADDR_W'(1);
                    state_d = S_IMM;
                end else begin
                    instr_d   = mem_rdata;
                    imm_d     = '0;
                    ifid_pc_d = pc;
                    valid_d   = 1'b1;
                    pc_d      = pc + ADDR_W'(1);
                end
            end
            // Interrupts are deliberately not considered here: the pair must complete.
            S_IMM: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_RUN;
                end else if (!stall) begin
                    instr_d   = held;
                    imm_d     = mem_rdata;
                    ifid_pc_d = pc - ADDR_W'(1);
                    valid_d   = 1'b1;
                    pc_d      = pc + ADDR_W'(1);
                    state_d   = S_RUN;
                end
            end
            S_INT: begin
                mem_addr = INT_VEC_ADDR;
                pc_d     = ADDR_W'(mem_rdata);
                state_d  = S_RUN;
            end
            S_HALT: begin
                valid_d = 1'b0;
                if (int_pending) begin
                    hlt_d   = 1'b0;
                    ret_d   = pc;
                    ack_d   = 1'b1;
                    int_clr = 1'b1;
                    state_d = S_INT;
                end
            end
            default: state_d = S_VEC;
        endcase
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the 8-bit pipelined processor.
- Owns the PC and loads it from the reset vector M[0], or from the interrupt vector M[1] on an interrupt.
- Fetches one- and two-byte instructions from the unified 256x8 memory and fills the IF/ID register consumed by decode.
- Honours stall, branch redirect and halt requests from later stages.

Parameters:
- ADDR_W, 8, PC/memory address width.
- DATA_W, 8, instruction byte width.
- RESET_VEC_ADDR, 8'h00, address holding the start PC.
- INT_VEC_ADDR, 8'h01, address holding the ISR start PC.
- TWO_BYTE_OPC, 4'hC, opcode (instr[7:4]) whose instructions carry an immediate byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  fetch address to memory (combinational read).
- mem_rdata  in  DATA_W  byte at mem_addr, same cycle.
- stall  in  1  hold PC and IF/ID (hazard or memory port busy).
- redirect  in  1  taken branch/jump/RET from a later stage.
- redirect_pc  in  ADDR_W  new PC when redirect=1.
- halt_req  in  1  HLT decoded; enter halt.
- int  in  1  external interrupt line, level.
- int_ack  out  1  one-cycle pulse when interrupt accepted.
- int_ret_pc  out  ADDR_W  return address captured at acceptance.
- pc  out  ADDR_W  current PC.
- ifid_valid  out  1  IF/ID holds a complete instruction.
- ifid_instr  out  DATA_W  opcode byte.
- ifid_imm  out  DATA_W  immediate byte (0 for one-byte instructions).
- ifid_pc  out  ADDR_W  address of ifid_instr.
- HLT  out  1  core halted.

Behaviour:
- Reset (rst=0, async): state=S_VEC; pc, ifid_*, int_ret_pc = 0; ifid_valid, int_ack, HLT = 0; pending interrupt and holding register cleared.
- S_VEC: mem_addr=RESET_VEC_ADDR. Next edge: pc<=mem_rdata, go S_RUN. PC equals M[0] one edge after release.
- S_RUN: mem_addr=pc. Priority per edge is redirect > halt_req > stall > interrupt > fetch.
  - redirect: pc<=redirect_pc, ifid_valid<=0, stay S_RUN. Applies even if stall=1.
  - halt_req: ifid_valid<=0, HLT<=1, pc frozen, go S_HALT.
  - stall: all registers hold.
  - pending interrupt: int_ret_pc<=pc, int_ack=1 for one cycle, ifid_valid<=0, go S_INT.
  - fetch, one-byte opcode: ifid_instr<=mem_rdata, ifid_imm<=0, ifid_pc<=pc, ifid_valid<=1, pc<=pc+1.
  - fetch, mem_rdata[7:4]==TWO_BYTE_OPC: hold byte, ifid_valid<=0, pc<=pc+1, go S_IMM.
- S_IMM: mem_addr=pc.
  - redirect: abort, drop held byte, pc<=redirect_pc, go S_RUN.
  - stall: hold.
  - else: ifid_instr<=held, ifid_imm<=mem_rdata, ifid_pc<=pc-1, ifid_valid<=1, pc<=pc+1, go S_RUN.
  - Interrupts are never taken between the two bytes.
- S_INT: mem_addr=INT_VEC_ADDR. Next edge: pc<=mem_rdata, clear pending, go S_RUN.
- S_HALT:
  - No fetch; outputs hold; ifid_valid=0; HLT=1.
  - Exit only by reset, or by a pending interrupt (HLT<=0, int_ret_pc<=pc, go S_INT).
- Interrupt capture: rising edge of int (registered previous value) sets pending. Further edges while pending are merged. An edge in the same cycle as acceptance re-arms pending.
- PC arithmetic is modulo 256: 8'hFF+1 = 8'h00, and a two-byte fetch at 8'hFF takes its immediate from 8'h00.

Optional Feature:
- Macro FETCH_INT_EN.
- Defined: interrupt logic as above.
- Undefined: int is ignored, int_ack=0, int_ret_pc=0, S_INT unreachable, S_HALT is left only by reset.

Decomposition:
- Package fetch_pkg holds the state encoding (S_VEC, S_RUN, S_IMM, S_INT, S_HALT), the vector address constants and TWO_BYTE_OPC.
- One sub-module, int_edge_latch: int rising-edge detector plus pending flag with clear input. It is the only part gated by FETCH_INT_EN.

Test Plan:
- M[0]=02, M[2]=21, M[3]=19, release reset -> pc=02 after 1 edge; next edge ifid_instr=21, ifid_pc=02, pc=03.
- M[2]=C4, M[3]=7A, M[4]=21 -> ifid_valid low one cycle, then ifid_instr=C4, ifid_imm=7A, ifid_pc=02; pc=04.
- stall=1 for 3 cycles mid-stream, with redirect=1 and redirect_pc=40 on the 2nd -> pc=40 next edge, ifid_valid=0, then fetch from 40 once stall drops.
- FETCH_INT_EN, M[1]=6E, int pulse while pc=05 -> int_ack one cycle, int_ret_pc=05, pc=6E two edges later. Repeat mid-two-byte fetch -> taken only after the immediate.
- halt_req at pc=08 -> HLT=1, pc stays 08. With FETCH_INT_EN, int edge -> HLT=0, pc=M[1]. Without it -> stays halted until reset.
- Assert rst=0 while in S_IMM -> outputs zero immediately (async). On release, pc=M[0]; pc wraps FF->00.
